// File: rtl/vga_sync_decoder_if.sv
// Bundle of the raw sync stream entering the decoder and the recovered
// pixel coordinates, strobes and lock status leaving it.
//
// Stream semantics: hSync/vSync/blankB are sampled every vgaClk edge and
// carry no ready. pixelValid qualifies xPos/yPos/lineStart/frameStart for
// exactly the cycle it is high; there is no backpressure, so a consumer
// must take every valid pixel on the cycle it is presented.
interface vga_sync_decoder_if;
    logic       hSync;
    logic       vSync;
    logic       blankB;
    logic       pixelValid;
    logic [9:0] xPos;
    logic [9:0] yPos;
    logic       lineStart;
    logic       frameStart;
    logic       locked;
    logic       frameErr;
    logic [1:0] dbg_state;

    // Stream source side (generator or bench)
    modport master (
        output hSync, vSync, blankB,
        input  pixelValid, xPos, yPos, lineStart, frameStart,
        input  locked, frameErr, dbg_state
    );

    // Decoder side
    modport slave (
        input  hSync, vSync, blankB,
        output pixelValid, xPos, yPos, lineStart, frameStart,
        output locked, frameErr, dbg_state
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: recovers pixel coordinates and line/frame
// strobes from a raw hSync/vSync/blankB stream, checks each frame against
// the expected active geometry, and reports lock after LOCK_FRAMES good
// frames in a row. A watchdog on hSync drops lock if the stream stalls.
module vga_sync_decoder #(
    parameter logic [9:0]  HACTIVE     = 10'd640,
    parameter logic [9:0]  VACTIVE     = 10'd480,
    parameter logic [2:0]  LOCK_FRAMES = 3'd2,
    parameter logic [10:0] TIMEOUT     = 11'd1200
) (
    input  logic              vgaClk,
    input  logic              rst,
    vga_sync_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0]  CNT_MAX = 10'h3FF;
    localparam logic [10:0] WD_MAX  = 11'h7FF;

    // Input stage. The sync copies reset high (idle level) so that a stream
    // already mid-pulse or mid-line at reset release is not mistaken for a
    // fresh edge; only a genuine low-to-high blankB transition opens a line.
    logic hs1_q, vs1_q, bl1_q;

    // Line tracking and counters
    logic        in_line_q,   in_line_d;
    logic [9:0]  x_cnt_q,     x_cnt_d;
    logic [9:0]  y_cnt_q,     y_cnt_d;
    logic        bad_frame_q, bad_frame_d;
    logic [10:0] wd_cnt_q,    wd_cnt_d;

    // Lock FSM
    state_t      state_q,     state_d;
    logic [2:0]  good_cnt_q,  good_cnt_d;

    // Registered outputs
    logic        pixel_valid_q, pixel_valid_d;
    logic [9:0]  x_pos_q,       x_pos_d;
    logic [9:0]  y_pos_q,       y_pos_d;
    logic        line_start_q,  line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q,      locked_d;
    logic        frame_err_q,   frame_err_d;

    // Edge events and derived conditions
    logic        h_edge, v_edge, act_rise, act_fall, pix;
    logic [10:0] line_w;
    logic        width_bad, frame_good, timeout;

    // Edge detection from raw input against its registered copy
    always_comb begin
        h_edge    = hs1_q & ~bus.hSync;
        v_edge    = vs1_q & ~bus.vSync;
        act_rise  = ~bl1_q & bus.blankB;
        // A fall only closes a line that was opened by a seen rise, so the
        // tail of a line cut by reset is neither counted nor width-checked.
        act_fall  = bl1_q & ~bus.blankB & in_line_q;
        pix       = bus.blankB & (act_rise | in_line_q);
        line_w    = {1'b0, x_cnt_q} + 11'd1;
        width_bad = act_fall & (line_w != {1'b0, HACTIVE});
        frame_good = ~bad_frame_q & (y_cnt_q == VACTIVE);
        timeout   = (wd_cnt_q >= TIMEOUT);
    end

    // Pixel/line counters, sticky geometry flag and hSync watchdog
    always_comb begin
        in_line_d   = in_line_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        bad_frame_d = bad_frame_q;
        wd_cnt_d    = wd_cnt_q;

        if (act_rise) begin
            in_line_d = 1'b1;
        end else if (!bus.blankB) begin
            in_line_d = 1'b0;
        end

        if (act_rise) begin
            x_cnt_d = 10'd0;
        end else if (pix && (x_cnt_q != CNT_MAX)) begin
            x_cnt_d = x_cnt_q + 10'd1;
        end

        // vSync clear wins over a coincident line increment
        if (v_edge) begin
            y_cnt_d = 10'd0;
        end else if (act_fall && (y_cnt_q != CNT_MAX)) begin
            y_cnt_d = y_cnt_q + 10'd1;
        end

        // The frame verdict is taken from the flag before this edge; the
        // flag then restarts clean for the frame that begins here.
        if (v_edge) begin
            bad_frame_d = 1'b0;
        end else if (width_bad) begin
            bad_frame_d = 1'b1;
        end

        if (h_edge) begin
            wd_cnt_d = 11'd0;
        end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + 11'd1;
        end
    end

    // Lock FSM next-state and error strobe
    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        frame_err_d = 1'b0;

        if (timeout) begin
            state_d     = SEARCH;
            good_cnt_d  = 3'd0;
            frame_err_d = (state_q == LOCKED);
        end else begin
            case (state_q)
                SEARCH: begin
                    // The frame in progress is of unknown start; skip it.
                    good_cnt_d = 3'd0;
                    if (v_edge) begin
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (v_edge) begin
                        if (frame_good) begin
                            good_cnt_d = good_cnt_q + 3'd1;
                            if ((good_cnt_q + 3'd1) == LOCK_FRAMES) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            good_cnt_d = 3'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (v_edge && !frame_good) begin
                        state_d     = TRACK;
                        good_cnt_d  = 3'd0;
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    good_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // Output staging: coordinates are zeroed outside active pixels
    always_comb begin
        pixel_valid_d = pix;
        x_pos_d       = pix ? x_cnt_d : 10'd0;
        y_pos_d       = pix ? y_cnt_d : 10'd0;
        line_start_d  = act_rise;
        frame_start_d = act_rise & (y_cnt_d == 10'd0);
        locked_d      = (state_d == LOCKED);
    end

    // Input registers, counters and FSM state
    always_ff @(posedge vgaClk or negedge rst) begin
        if (!rst) begin
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            bl1_q       <= 1'b1;
            in_line_q   <= 1'b0;
            x_cnt_q     <= 10'd0;
            y_cnt_q     <= 10'd0;
            bad_frame_q <= 1'b0;
            wd_cnt_q    <= 11'd0;
            state_q     <= SEARCH;
            good_cnt_q  <= 3'd0;
        end else begin
            hs1_q       <= bus.hSync;
            vs1_q       <= bus.vSync;
            bl1_q       <= bus.blankB;
            in_line_q   <= in_line_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            bad_frame_q <= bad_frame_d;
            wd_cnt_q    <= wd_cnt_d;
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
        end
    end

    // Output registers
    always_ff @(posedge vgaClk or negedge rst) begin
        if (!rst) begin
            pixel_valid_q <= 1'b0;
            x_pos_q       <= 10'd0;
            y_pos_q       <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            pixel_valid_q <= pixel_valid_d;
            x_pos_q       <= x_pos_d;
            y_pos_q       <= y_pos_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.pixelValid = pixel_valid_q;
    assign bus.xPos       = x_pos_q;
    assign bus.yPos       = y_pos_q;
    assign bus.lineStart  = line_start_q;
    assign bus.frameStart = frame_start_q;
    assign bus.locked     = locked_q;
    assign bus.frameErr   = frame_err_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster: 16 active
// pixels per line, 6 active lines per frame, 3 blanking lines with vSync
// low on the second. Each line is active + 4 front porch + 2 hSync + 2 back
// porch clocks. Watchdog left at its default of 1200 clocks.
module tb_vga_sync_decoder;
    localparam logic [9:0] HACT = 10'd16;
    localparam logic [9:0] VACT = 10'd6;

    logic vgaClk = 1'b0;
    logic rst    = 1'b0;

    vga_sync_decoder_if vif ();

    vga_sync_decoder #(
        .HACTIVE     (HACT),
        .VACTIVE     (VACT),
        .LOCK_FRAMES (3'd2),
        .TIMEOUT     (11'd1200)
    ) dut (
        .vgaClk (vgaClk),
        .rst    (rst),
        .bus    (vif)
    );

    // Clock
    always #5 vgaClk = ~vgaClk;

    int tests_run    = 0;
    int tests_failed = 0;
    int fe_count     = 0;

    // frameErr pulse counter, sampled away from the active edge
    always @(negedge vgaClk) begin
        if (vif.frameErr === 1'b1) fe_count++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Captures from the line/frame drivers
    logic       f_pv, f_ls, f_fs, v_lk, v_fe;
    logic [9:0] f_x, f_y, l_x, x_prev, x_at_1023, odd_last_x;
    logic       x_wrap, pre_lk, fr_lk, fr_fe, pv_seen;
    logic [24:0] outs;

    assign outs = {vif.pixelValid, vif.xPos, vif.yPos, vif.lineStart,
                   vif.frameStart, vif.locked, vif.frameErr};

    task automatic cyc1(input logic h, input logic v, input logic b);
        vif.hSync  = h;
        vif.vSync  = v;
        vif.blankB = b;
        @(posedge vgaClk);
        #1;
    endtask

    task automatic drive_line(input int act, input logic vis, input logic vs_low, input logic hs_en);
        for (int c = 0; c < act + 8; c++) begin
            cyc1(!(hs_en && c >= act + 4 && c < act + 6), !vs_low, vis && (c < act));
            if (c == 0) begin
                f_pv = vif.pixelValid; f_x = vif.xPos; f_y = vif.yPos;
                f_ls = vif.lineStart;  f_fs = vif.frameStart;
                v_lk = vif.locked;     v_fe = vif.frameErr;
            end
            if (c == act - 1) l_x = vif.xPos;
            if (c == 1023) x_at_1023 = vif.xPos;
            if (vif.pixelValid && c > 0 && vif.xPos < x_prev) x_wrap = 1'b1;
            x_prev = vif.xPos;
        end
    endtask

    // One frame; line odd_line gets odd_act active pixels instead of HACT.
    task automatic drive_frame(input int odd_line, input int odd_act, input logic chk);
        for (int y = 0; y < int'(VACT); y++) begin
            drive_line((y == odd_line) ? odd_act : int'(HACT), 1'b1, 1'b0, 1'b1);
            if (y == odd_line) odd_last_x = l_x;
            if (chk && y == 0) begin
                check_eq("first_pixel_valid", 32'(f_pv), 32'd1);
                check_eq("first_pixel_x", 32'(f_x), 32'd0);
                check_eq("first_pixel_y", 32'(f_y), 32'd0);
                check_eq("first_line_start", 32'(f_ls), 32'd1);
                check_eq("first_frame_start", 32'(f_fs), 32'd1);
            end
            if (chk && y == int'(VACT) - 1) begin
                check_eq("last_line_y", 32'(f_y), 32'd5);
                check_eq("last_pixel_x", 32'(l_x), 32'd15);
            end
        end
        drive_line(int'(HACT), 1'b0, 1'b0, 1'b1);
        pre_lk = vif.locked;
        drive_line(int'(HACT), 1'b0, 1'b1, 1'b1);
        fr_lk = v_lk;
        fr_fe = v_fe;
        drive_line(int'(HACT), 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic lk_c, fe_c;
        vif.hSync = 1'b1; vif.vSync = 1'b1; vif.blankB = 1'b0;
        x_wrap = 1'b0; x_prev = 10'd0;
        repeat (3) @(posedge vgaClk);
        #1;
        check_eq("reset_outputs", 32'(outs), 32'd0);
        check_eq("reset_state", 32'(vif.dbg_state), 32'd0);
        rst = 1'b1;
        repeat (4) cyc1(1'b1, 1'b1, 1'b0);

        // Acquisition: SEARCH -> TRACK -> two good frames -> LOCKED
        drive_frame(-1, 0, 1'b1);
        check_eq("f1_locked", 32'(fr_lk), 32'd0);
        check_eq("f1_state_track", 32'(vif.dbg_state), 32'd1);
        drive_frame(-1, 0, 1'b0);
        check_eq("f2_locked", 32'(fr_lk), 32'd0);
        drive_frame(-1, 0, 1'b0);
        check_eq("f3_pre_locked", 32'(pre_lk), 32'd0);
        check_eq("f3_locked_at_vedge", 32'(fr_lk), 32'd1);
        check_eq("f3_state_locked", 32'(vif.dbg_state), 32'd2);
        drive_frame(-1, 0, 1'b1);
        check_eq("f4_locked", 32'(fr_lk), 32'd1);
        check_eq("clean_no_frame_err", 32'(fe_count), 32'd0);

        // Short line: 15 active pixels on line 2
        drive_frame(2, 15, 1'b0);
        check_eq("short_last_x", 32'(odd_last_x), 32'd14);
        check_eq("short_pre_locked", 32'(pre_lk), 32'd1);
        check_eq("short_frame_err", 32'(fr_fe), 32'd1);
        check_eq("short_locked_drop", 32'(fr_lk), 32'd0);
        check_eq("short_err_count", 32'(fe_count), 32'd1);
        drive_frame(-1, 0, 1'b0);
        check_eq("relock1_locked", 32'(fr_lk), 32'd0);
        drive_frame(-1, 0, 1'b0);
        check_eq("relock2_locked", 32'(fr_lk), 32'd1);

        // Watchdog: no hSync for well over 1200 clocks
        repeat (1100) cyc1(1'b1, 1'b1, 1'b0);
        check_eq("wd_before_timeout", 32'(vif.locked), 32'd1);
        repeat (150) cyc1(1'b1, 1'b1, 1'b0);
        check_eq("wd_locked_drop", 32'(vif.locked), 32'd0);
        check_eq("wd_err_count", 32'(fe_count), 32'd2);
        check_eq("wd_state_search", 32'(vif.dbg_state), 32'd0);
        drive_frame(-1, 0, 1'b0);
        check_eq("wd_relock_f1", 32'(fr_lk), 32'd0);
        check_eq("wd_relock_track", 32'(vif.dbg_state), 32'd1);
        drive_frame(-1, 0, 1'b0);
        check_eq("wd_relock_f2", 32'(fr_lk), 32'd0);
        drive_frame(-1, 0, 1'b0);
        check_eq("wd_relock_f3", 32'(fr_lk), 32'd1);

        // vEdge coincident with actFall on the 6th line
        for (int y = 0; y < 5; y++) drive_line(int'(HACT), 1'b1, 1'b0, 1'b1);
        lk_c = 1'b0; fe_c = 1'b0;
        for (int c = 0; c < 24; c++) begin
            cyc1(!(c == 20 || c == 21), c < 16, c < 16);
            if (c == 16) begin lk_c = vif.locked; fe_c = vif.frameErr; end
        end
        check_eq("coinc_frame_err", 32'(fe_c), 32'd1);
        check_eq("coinc_locked_drop", 32'(lk_c), 32'd0);
        drive_line(int'(HACT), 1'b0, 1'b1, 1'b1);
        drive_line(int'(HACT), 1'b0, 1'b0, 1'b1);
        drive_frame(-1, 0, 1'b1);
        check_eq("coinc_next_locked", 32'(fr_lk), 32'd0);
        check_eq("coinc_err_count", 32'(fe_count), 32'd3);
        drive_frame(-1, 0, 1'b0);
        check_eq("coinc_relock", 32'(fr_lk), 32'd1);

        // Saturation: line 2 carries 1100 active clocks
        x_wrap = 1'b0;
        drive_frame(2, 1100, 1'b0);
        check_eq("sat_x_at_1023", 32'(x_at_1023), 32'd1023);
        check_eq("sat_x_last", 32'(odd_last_x), 32'd1023);
        check_eq("sat_no_wrap", 32'(x_wrap), 32'd0);
        check_eq("sat_frame_err", 32'(fr_fe), 32'd1);
        check_eq("sat_locked_drop", 32'(fr_lk), 32'd0);
        check_eq("sat_err_count", 32'(fe_count), 32'd4);

        // Reset mid-line at xPos=300
        for (int c = 0; c < 301; c++) cyc1(1'b1, 1'b1, 1'b1);
        check_eq("pre_reset_x", 32'(vif.xPos), 32'd300);
        rst = 1'b0;
        #1;
        check_eq("reset_async_outputs", 32'(outs), 32'd0);
        repeat (3) begin
            cyc1(1'b1, 1'b1, 1'b1);
            check_eq("reset_hold_outputs", 32'(outs), 32'd0);
        end
        rst = 1'b1;
        pv_seen = 1'b0;
        repeat (20) begin
            cyc1(1'b1, 1'b1, 1'b1);
            pv_seen = pv_seen | vif.pixelValid;
        end
        for (int c = 0; c < 8; c++) begin
            cyc1(!(c == 4 || c == 5), 1'b1, 1'b0);
            pv_seen = pv_seen | vif.pixelValid;
        end
        check_eq("post_reset_no_pixel", 32'(pv_seen), 32'd0);
        drive_line(int'(HACT), 1'b1, 1'b0, 1'b1);
        check_eq("post_reset_pv", 32'(f_pv), 32'd1);
        check_eq("post_reset_x0", 32'(f_x), 32'd0);
        check_eq("post_reset_y0", 32'(f_y), 32'd0);
        check_eq("post_reset_line_start", 32'(f_ls), 32'd1);
        check_eq("post_reset_last_x", 32'(l_x), 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
